// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } arbState_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// rrPtr names the port favoured when both request in IDLE.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic      req0,
  input  logic      req1,
  input  arbState_t state,
  input  logic      rrPtr,
  output logic      gnt0,
  output logic      gnt1,
  output logic      owner
);

  // Grant the owner while locked, otherwise resolve conflicts through rrPtr
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    owner = PORT_CPU;
    case (state)
      LOCK0: begin
        gnt0 = req0;
      end
      LOCK1: begin
        gnt1  = req1;
        owner = PORT_DBG;
      end
      default: begin
        if (req0 && req1) begin
          owner = rrPtr;
          gnt0  = (rrPtr == PORT_CPU);
          gnt1  = (rrPtr == PORT_DBG);
        end else if (req1) begin
          gnt1  = 1'b1;
          owner = PORT_DBG;
        end else begin
          gnt0 = req0;
        end
      end
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory (CPU = port 0,
// debug/loader = port 1). Optional round-robin IDLE arbitration is enabled
// by defining DMEM_ARB_RR_EN; the default build uses fixed priority to port 0.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              sysCLK,
  input  logic              resetN,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataW,
  output logic              memRW,
  input  logic [DATA_W-1:0] memDataR,
  output logic [CNT_W-1:0]  stallCnt
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  arbState_t state;
  arbState_t stateNext;
  logic      pickGnt0;
  logic      pickGnt1;
  logic      owner;
  logic      rrPtr;
  logic      vld_p1;
  logic      owner_p1;
  logic      stall;

  dmem_arb_pick uPick (
    .req0  (req0),
    .req1  (req1),
    .state (state),
    .rrPtr (rrPtr),
    .gnt0  (pickGnt0),
    .gnt1  (pickGnt1),
    .owner (owner)
  );

  // Grants are forced low while reset is asserted
  assign gnt0 = pickGnt0 & resetN;
  assign gnt1 = pickGnt1 & resetN;

`ifdef DMEM_ARB_RR_EN
  // After any grant, favour the other port on the next conflict
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN)
      rrPtr <= PORT_CPU;
    else if (gnt0 || gnt1)
      rrPtr <= ~owner;
  end
`else
  assign rrPtr = PORT_CPU;
`endif

  // State register
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // Next state: enter a lock on a locked grant, leave when owner releases or drops req
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (gnt0 && lock0)
          stateNext = LOCK0;
        else if (gnt1 && lock1)
          stateNext = LOCK1;
      end
      LOCK0: begin
        if (!req0 || !lock0)
          stateNext = IDLE;
      end
      LOCK1: begin
        if (!req1 || !lock1)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Steer the winner onto the memory port; idle bus is all zeros
  always_comb begin
    memAddr  = '0;
    memDataW = '0;
    memRW    = 1'b0;
    if (gnt0) begin
      memAddr  = addr0;
      memDataW = wdata0;
      memRW    = we0;
    end else if (gnt1) begin
      memAddr  = addr1;
      memDataW = wdata1;
      memRW    = we1;
    end
  end

  // ---- stage p1: read return, keyed by the owner tag captured at grant ----
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      vld_p1   <= 1'b0;
      owner_p1 <= PORT_CPU;
    end else begin
      vld_p1   <= (gnt0 & ~we0) | (gnt1 & ~we1);
      owner_p1 <= owner;
    end
  end

  assign rvalid0 = vld_p1 & (owner_p1 == PORT_CPU);
  assign rvalid1 = vld_p1 & (owner_p1 == PORT_DBG);
  assign rdata0  = rvalid0 ? memDataR : '0;
  assign rdata1  = rvalid1 ? memDataR : '0;

  assign stall = (req0 & ~gnt0) | (req1 & ~gnt1);

  // Count cycles where some requester is held off, saturating at all-ones
  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN)
      stallCnt <= '0;
    else if (stall)
      stallCnt <= satInc(stallCnt);
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small memory model and a
// read-return scoreboard.
module tb_dmem_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;

  logic              sysCLK;
  logic              resetN;
  logic              req0, req1, we0, we1, lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataW;
  logic              memRW;
  logic [DATA_W-1:0] memDataR;
  logic [CNT_W-1:0]  stallCnt;

  dmem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .sysCLK   (sysCLK),
    .resetN   (resetN),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .lock0    (lock0),
    .lock1    (lock1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .memAddr  (memAddr),
    .memDataW (memDataW),
    .memRW    (memRW),
    .memDataR (memDataR),
    .stallCnt (stallCnt)
  );

  initial sysCLK = 1'b0;
  always #5 sysCLK = ~sysCLK;

  // Memory model: synchronous write, registered read address
  logic [DATA_W-1:0] memArr [0:255];
  logic [255:0]      wrFlag = '0;
  logic [ADDR_W-1:0] addrQ  = '0;

  function automatic logic [DATA_W-1:0] initWord(input logic [ADDR_W-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  always @(posedge sysCLK) begin
    if (memRW) begin
      memArr[memAddr[7:0]] <= memDataW;
      wrFlag[memAddr[7:0]] <= 1'b1;
    end
    addrQ <= memAddr;
  end

  assign memDataR = wrFlag[addrQ[7:0]] ? memArr[addrQ[7:0]] : initWord(addrQ);

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  exp_t sbQ[$];
  int   cyc;
  int   nAsserts;
  int   nFail;
  logic first;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [DATA_W-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    e.due  = cyc + 1;
    sbQ.push_back(e);
  endtask

  // Check the read-return outputs of the current cycle, then advance one clock
  task automatic cycle();
    exp_t e;
    if (sbQ.size() > 0 && sbQ[0].due == cyc) begin
      e = sbQ.pop_front();
      if (e.port == 1'b0) begin
        chk("rvalid0", rvalid0, 1);
        chk("rdata0", rdata0, e.data);
        chk("rvalid1 other", rvalid1, 0);
        chk("rdata1 other", rdata1, 0);
      end else begin
        chk("rvalid1", rvalid1, 1);
        chk("rdata1", rdata1, e.data);
        chk("rvalid0 other", rvalid0, 0);
        chk("rdata0 other", rdata0, 0);
      end
    end else begin
      chk("rvalid0 quiet", rvalid0, 0);
      chk("rvalid1 quiet", rvalid1, 0);
    end
    @(posedge sysCLK);
    cyc++;
    #1;
  endtask

  initial begin
    nAsserts = 0;
    nFail    = 0;
    cyc      = 0;
    resetN   = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    #2;
    chk("reset gnt0", gnt0, 0);
    chk("reset gnt1", gnt1, 0);
    chk("reset memRW", memRW, 0);
    chk("reset stallCnt", stallCnt, 0);
    chk("reset rvalid0", rvalid0, 0);
    chk("reset rvalid1", rvalid1, 0);
    req0 = 1; we0 = 1;
    #1;
    chk("gnt0 in reset", gnt0, 0);
    chk("memRW in reset", memRW, 0);
    req0 = 0; we0 = 0;
    @(posedge sysCLK);
    @(posedge sysCLK);
    #1;
    resetN = 1'b1;
    #1;

    // Single read from port 0
    req0 = 1; we0 = 0; addr0 = 16'h0010;
    #1;
    chk("t1 gnt0", gnt0, 1);
    chk("t1 gnt1", gnt1, 0);
    chk("t1 memAddr", memAddr, 32'h0010);
    chk("t1 memRW", memRW, 0);
    push(0, 32'hDEADBEEF);
    cycle();
    req0 = 0;
    #1;
    chk("t1 gnt0 drop", gnt0, 0);
    cycle();

    // Simultaneous reads
`ifdef DMEM_ARB_RR_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    req0 = 1; addr0 = 16'h0010; req1 = 1; we1 = 0; addr1 = 16'h0011;
    #1;
    chk("t2 first gnt0", gnt0, {31'd0, ~first});
    chk("t2 first gnt1", gnt1, {31'd0, first});
    push(first, first ? 32'hA5A50011 : 32'hDEADBEEF);
    cycle();
    if (first) req1 = 0; else req0 = 0;
    #1;
    chk("t2 second gnt0", gnt0, {31'd0, first});
    chk("t2 second gnt1", gnt1, {31'd0, ~first});
    push(~first, first ? 32'hDEADBEEF : 32'hA5A50011);
    cycle();
    req0 = 0; req1 = 0;
    #1;
    chk("t2 stallCnt", stallCnt, 1);
    cycle();

    // Locked write then read-back from port 1 while port 0 waits
    req1 = 1; we1 = 1; lock1 = 1; addr1 = 16'h0020; wdata1 = 32'h12345678;
    #1;
    chk("t3 wr gnt1", gnt1, 1);
    chk("t3 wr memRW", memRW, 1);
    chk("t3 wr memAddr", memAddr, 32'h0020);
    chk("t3 wr memDataW", memDataW, 32'h12345678);
    cycle();
    we1 = 0; req0 = 1; we0 = 0; addr0 = 16'h0010;
    #1;
    chk("t3 locked gnt0", gnt0, 0);
    chk("t3 locked gnt1", gnt1, 1);
    push(1, 32'h12345678);
    cycle();
    lock1 = 0;
    #1;
    chk("t3 release gnt0", gnt0, 0);
    chk("t3 release gnt1", gnt1, 1);
    push(1, 32'h12345678);
    cycle();
    req1 = 0;
    #1;
    chk("t3 after gnt0", gnt0, 1);
    chk("t3 after gnt1", gnt1, 0);
    chk("t3 stallCnt", stallCnt, 3);
    push(0, 32'hDEADBEEF);
    cycle();
    req0 = 0;
    #1;
    cycle();

    // Sustained conflict: alternation under round-robin, port 0 otherwise
    req1 = 1; addr1 = 16'h0011;
    #1;
    chk("t4 prime gnt1", gnt1, 1);
    push(1, 32'hA5A50011);
    cycle();
    req0 = 1; addr0 = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      logic exp;
`ifdef DMEM_ARB_RR_EN
      exp = (i % 2) == 1;
`else
      exp = 1'b0;
`endif
      #1;
      chk($sformatf("t4 gnt0[%0d]", i), gnt0, {31'd0, ~exp});
      chk($sformatf("t4 gnt1[%0d]", i), gnt1, {31'd0, exp});
      push(exp, exp ? 32'hA5A50011 : 32'hDEADBEEF);
      cycle();
    end
    req0 = 0; req1 = 0;
    #1;
    chk("t4 stallCnt", stallCnt, 7);
    cycle();

    // Reset right after a locked read grant drops the return
    req1 = 1; we1 = 0; lock1 = 1; addr1 = 16'h0011;
    #1;
    chk("t5 gnt1", gnt1, 1);
    cycle();
    req1 = 0; lock1 = 0;
    resetN = 1'b0;
    #1;
    chk("t5 rvalid1 dropped", rvalid1, 0);
    chk("t5 rvalid0 dropped", rvalid0, 0);
    chk("t5 stallCnt", stallCnt, 0);
    @(posedge sysCLK);
    @(posedge sysCLK);
    cyc += 2;
    #1;
    chk("t5 rvalid1 held", rvalid1, 0);
    resetN = 1'b1;
    #1;
    req0 = 1; addr0 = 16'h0010; req1 = 1; addr1 = 16'h0011;
    #1;
    chk("t5 idle gnt0", gnt0, 1);
    chk("t5 idle gnt1", gnt1, 0);
    push(0, 32'hDEADBEEF);
    cycle();
    req0 = 0;
    #1;
    chk("t5 next gnt1", gnt1, 1);
    push(1, 32'hA5A50011);
    cycle();
    req1 = 0;
    #1;
    cycle();

    // Stall counter saturation over 2^CNT_W+3 stalled cycles
    resetN = 1'b0;
    #1;
    resetN = 1'b1;
    #1;
    chk("t6 stallCnt start", stallCnt, 0);
    req0 = 1; we0 = 1; addr0 = 16'h0030; wdata0 = 32'd1;
    req1 = 1; we1 = 1; addr1 = 16'h0031; wdata1 = 32'd2;
    repeat (65534) @(posedge sysCLK);
    cyc += 65534;
    #1;
    chk("t6 stallCnt near", stallCnt, 32'hFFFE);
    repeat (5) @(posedge sysCLK);
    cyc += 5;
    #1;
    chk("t6 stallCnt sat", stallCnt, 32'hFFFF);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    #1;
    chk("t6 idle gnt0", gnt0, 0);
    chk("t6 idle gnt1", gnt1, 0);
    cycle();
    chk("t6 stallCnt hold", stallCnt, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
